// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg -- shared AES definitions for the iterative encrypt/decrypt cores.
//
// Contents:
//   aes_state_e : FSM state encoding (IDLE / ROUND / DONE)
//   SBOX / sbox : forward S-box table and lookup
//   xtime       : multiply by x (0x02) in GF(2^8), poly x^8+x^4+x^3+x+1
//   gf_mul      : general GF(2^8) multiply
//   round_key   : slice round key r out of a zero-padded key schedule
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    localparam int RK_BITS    = 128;
    // A 4-bit round counter can address 16 round keys; schedules are padded
    // to this size so one helper serves every key length.
    localparam int MAX_RK     = 16;
    localparam int W_PAD_BITS = MAX_RK * RK_BITS;

    // Entry 0 is the most significant byte, so SBOX[x] is the substitution of x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Round key r occupies bits [r*128 +: 128]; the lowest-numbered bit is
    // the key's most significant bit.
    function automatic logic [127:0] round_key(input logic [0:W_PAD_BITS-1] w_pad,
                                               input logic [3:0] r);
        return w_pad[{r, 7'd0} +: RK_BITS];
    endfunction

endpackage

// File: rtl/round_forward.sv
// ---------------------------------------------------------------------------
// round_forward -- one combinational AES forward round.
//   SubBytes -> ShiftRows -> MixColumns (skipped when last_i) -> AddRoundKey
//
// Ports:
//   state_i     in  128 : round input, byte 0 in bits [127:120]
//   round_key_i in  128 : key added at the end of the round
//   last_i      in  1   : final round, MixColumns bypassed
//   state_o     out 128 : round output
// ---------------------------------------------------------------------------
module round_forward
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    always_comb begin
        logic [7:0] sb [16];
        logic [7:0] sr [16];
        logic [7:0] mc [16];
        logic [7:0] a0, a1, a2, a3;

        state_o = '0;

        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state_i[127-8*i -: 8]);
        end

        // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r + 4*((c+r)%4)];
            end
        end

        // MixColumns with 2*a = xtime(a) and 3*a = xtime(a)^a.
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end

        for (int i = 0; i < 16; i++) begin
            state_o[127-8*i -: 8] = (last_i ? sr[i] : mc[i]) ^ round_key_i[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/encrypt_core.sv
// ---------------------------------------------------------------------------
// encrypt_core -- iterative AES forward cipher, one round per clock.
//
// Parameters:
//   nk : key length in 32-bit words (4/6/8)
//   nr : number of rounds (10/12/14), must equal nk+6
// Ports:
//   clk       in  1   : rising-edge clock
//   rst_n     in  1   : asynchronous active-low reset
//   in_valid  in  1   : plaintext offered
//   in_ready  out 1   : high only in IDLE
//   state_in  in  128 : plaintext, byte 0 in bits [127:120], sampled on accept
//   w         in  (nr+1)*128 : expanded key, round key r at w[r*128 +: 128];
//                              not latched, must stay stable while encrypting
//   out_valid out 1   : ciphertext available (DONE)
//   out_ready in  1   : consumer accepts ciphertext
//   out1      out 128 : ciphertext
// Build option:
//   ENCRYPT_ZERO_OUT_EN : when defined, out1 reads 0 whenever out_valid is 0;
//                         otherwise out1 mirrors the round state at all times.
// ---------------------------------------------------------------------------
module encrypt_core
    import aes_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            state_in,
    input  logic [0:(nr+1)*128-1]   w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out1
);

    if (nr != nk + 6) begin : g_bad_params
        $error("encrypt_core: nr must equal nk+6");
    end

    localparam logic [3:0] LAST_RND = 4'(nr);

    aes_state_e   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;

    logic [0:W_PAD_BITS-1] w_pad;
    logic [127:0]          rk_cur;
    logic [127:0]          round_out;

    always_comb begin
        w_pad = '0;
        w_pad[0:(nr+1)*128-1] = w;
    end

    assign rk_cur = round_key(w_pad, rnd_q);

    round_forward u_round (
        .state_i     (st_q),
        .round_key_i (rk_cur),
        .last_i      (rnd_q == LAST_RND),
        .state_o     (round_out)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the 128-bit round state is also reset because its value
    // is visible on out1 and must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = state_in ^ round_key(w_pad, 4'd0);
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d = round_out;
                if (rnd_q == LAST_RND) begin
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ENCRYPT_ZERO_OUT_EN
        out1 = (state_q == DONE) ? st_q : '0;
`else
        out1 = st_q;
`endif
    end

endmodule

// File: doc/encrypt_core.md
# encrypt_core

Iterative AES forward cipher (FIPS-197): takes one 128-bit plaintext block and a precomputed expanded key schedule, and produces the ciphertext after one initial AddRoundKey plus nr rounds, one round per clock. It is the encrypt-direction counterpart of the iterative decrypt datapath. It sits between the key-expansion block, which supplies `w`, and the system data path. Both sides use valid/ready handshakes.

## Interface
- `nk`, default 4: key length in 32-bit words (4/6/8).
- `nr`, default 10: number of rounds (10/12/14). Must equal nk+6.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: plaintext offered.
- `in_ready` out 1: block can accept plaintext.
- `state_in` in 128: plaintext, byte 0 in bits [127:120].
- `w` in [0:(nr+1)*128-1]: expanded key. Round key r is `w[r*128 +: 128]`.
- `out_valid` out 1: ciphertext available.
- `out_ready` in 1: consumer accepts ciphertext.
- `out1` out 128: ciphertext.

## Operation
- FSM states: IDLE, ROUND, DONE. Round counter `rnd` is 4 bits wide, values 0..nr.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: `st` <= `state_in ^ w[0*128+:128]`, `rnd` <= 1, go to ROUND.
- ROUND, when `rnd` < nr: `st` <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), round key `rnd`), then `rnd`++.
- ROUND, when `rnd` == nr: `st` <= final round (no MixColumns) with round key nr, then go to DONE.
- DONE:
  - `out_valid`=1 and `out1`=`st`.
  - On `out_ready`: go to IDLE.
  - Ciphertext and `out_valid` hold stable until accepted.
- `in_ready` is 1 only in IDLE. An input offered in DONE stalls until the cycle after the output handshake.
- `w` is not latched. The driver must hold `w` stable from the accept edge through the edge that enters DONE.
- `state_in` is sampled only on the accept edge.
- X/undefined inputs are not filtered. `in_valid` is the only qualifier.

## Timing
- Reset values (async on `rst_n` low): FSM=IDLE, `rnd`=0, `st`=0, `in_ready`=1, `out_valid`=0, `out1`=0.
- Latency: ciphertext appears with `out_valid`=1 exactly nr cycles after the accept edge (10/12/14).
- Throughput: one block per nr+2 cycles when `out_ready` is held at 1.
- `out_ready`=1 in the first DONE cycle: the handshake completes there, and IDLE follows on the next edge.
- Reset mid-operation: everything returns to reset values immediately. The in-flight block is discarded, and no `out_valid` pulse is produced.
- `in_valid` deasserted in IDLE: the FSM stays in IDLE and `st` is unchanged.
- `in_valid`/`out_ready` toggling during ROUND has no effect.

## Configuration
- `ENCRYPT_ZERO_OUT_EN` defined: `out1` is forced to 0 whenever `out_valid`=0, so intermediate round state is never visible on the port.
- `ENCRYPT_ZERO_OUT_EN` undefined: `out1`=`st` at all times. Intermediate states are visible during ROUND, and reset still gives 0.
- `out_valid` timing is identical in both builds.

## Structure
- Shared package `aes_pkg` holds:
  - FSM state encoding (IDLE/ROUND/DONE);
  - the S-box table and the xtime/GF(2^8) multiply function;
  - the round-key slicing helper.
  The decrypt side reuses the same package.
- One sub-module, `round_forward`:
  - combinational SubBytes/ShiftRows/MixColumns/AddRoundKey;
  - a `last` input bypasses MixColumns.
  The core instantiates it once and indexes `w` by `rnd`.

## Test plan
- FIPS-197 App. B, nk=4: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out1=3925841d02dc09fbdc118597196a0b32, `out_valid` exactly 10 cycles after the accept edge.
- App. C.1/C.2/C.3 (key 000102…, pt 00112233445566778899aabbccddeeff):
  - nk=4 -> 69c4e0d86a7b0430d8cdb78070b4c55a;
  - nk=6 -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 12;
  - nk=8 -> 8ea2b7ca516745bfeafc49904b496089, latency 14.
- Backpressure: hold `out_ready`=0 for 5 cycles after DONE. Required: `out1`/`out_valid` stable, `in_ready`=0 and `in_valid` ignored throughout, then one handshake and return to IDLE.
- Back-to-back: two blocks with `in_valid`/`out_ready` tied to 1. Required: both correct, second accept exactly 12 cycles after the first (nk=4).
- Reset mid-ROUND (`rst_n` low at round 5): all outputs at reset values immediately, no `out_valid`. A following block encrypts correctly.
- With `ENCRYPT_ZERO_OUT_EN`: `out1`==0 in every non-DONE cycle. Without it: `out1` after the accept edge equals pt^w[0] (App. B: 193de3bea0f4e22b9ac68d2ae9f84808).
